// File: rtl/dw02_mac.sv
// Multiply-accumulate MAC = A*B + C (mod 2^(A_width+B_width)), unsigned or two's complement per TC.
// Define DW02_MAC_OUT_REG_EN to register MAC on MAC_ACC_CLK with async clear from acc_ff_rstn.

// One partial-product row. The top row of B carries negative weight in signed mode,
// so it is inverted here and the +1 of the negation enters as a separate row.
module dw02_mac_pp #(
  parameter int P     = 16,
  parameter int SHIFT = 0,
  parameter bit NEG   = 1'b0
) (
  input  logic [P-1:0] a_ext,
  input  logic         b_bit,
  input  logic         tc,
  output logic [P-1:0] pp
);
  logic [P-1:0] raw;

  assign raw = b_bit ? (a_ext << SHIFT) : '0;
  assign pp  = raw ^ {P{tc & NEG}};
endmodule

// 3:2 carry-save row; carry leaves pre-shifted, anything above bit P-1 is dropped (mod 2^P).
module dw02_mac_csa #(
  parameter int P = 16
) (
  input  logic [P-1:0] x,
  input  logic [P-1:0] y,
  input  logic [P-1:0] z,
  output logic [P-1:0] s,
  output logic [P-1:0] c
);
  logic [P-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[P-2:0] & y[P-2:0]) | (x[P-2:0] & z[P-2:0]) | (y[P-2:0] & z[P-2:0]);
  assign c   = {maj, 1'b0};
endmodule

module dw02_mac #(
  parameter int A_width = 8,
  parameter int B_width = 8
) (
  input  logic                       MAC_ACC_CLK,
  input  logic                       acc_ff_rstn,
  input  logic [A_width-1:0]         A,
  input  logic [B_width-1:0]         B,
  input  logic [A_width+B_width-1:0] C,
  input  logic                       TC,
  output logic [A_width+B_width-1:0] MAC
);
  localparam int P    = A_width + B_width;
  localparam int ROWS = B_width + 2;

  logic [P-1:0]              a_ext;
  logic [ROWS-1:0][P-1:0]    rows;
  logic [ROWS-2:0][P-1:0]    s_ch;
  logic [ROWS-2:0][P-1:0]    c_ch;
  logic [P-1:0]              sum;
  logic [P-1:0]              mac_nxt;

  // Full-precision multiplicand: sign-extended only in two's-complement mode.
  assign a_ext = {{B_width{TC & A[A_width-1]}}, A};

  for (genvar j = 0; j < B_width; j++) begin : g_pp
    dw02_mac_pp #(
      .P     (P),
      .SHIFT (j),
      .NEG   (j == B_width - 1)
    ) u_pp (
      .a_ext (a_ext),
      .b_bit (B[j]),
      .tc    (TC),
      .pp    (rows[j])
    );
  end

  assign rows[B_width]   = P'(TC);
  assign rows[B_width+1] = C;

  // Linear carry-save array: each stage folds one more row into the (sum, carry) pair.
  assign s_ch[0] = rows[0];
  assign c_ch[0] = rows[1];

  for (genvar k = 0; k < ROWS - 2; k++) begin : g_csa
    dw02_mac_csa #(
      .P (P)
    ) u_csa (
      .x (s_ch[k]),
      .y (c_ch[k]),
      .z (rows[k+2]),
      .s (s_ch[k+1]),
      .c (c_ch[k+1])
    );
  end

  assign sum = s_ch[ROWS-2] + c_ch[ROWS-2];

  always_comb begin
    mac_nxt = sum;
`ifndef SYNTHESIS
    if ($isunknown({A, B, C, TC})) mac_nxt = 'x;
`endif
  end

`ifdef DW02_MAC_OUT_REG_EN
  logic [P-1:0] mac_q;

  always_ff @(posedge MAC_ACC_CLK or negedge acc_ff_rstn) begin
    if (!acc_ff_rstn) mac_q <= '0;
    else              mac_q <= mac_nxt;
  end

  assign MAC = mac_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = MAC_ACC_CLK ^ acc_ff_rstn;
  assign MAC            = mac_nxt;
`endif
endmodule

// File: tb/tb_dw02_mac.sv
// Scoreboarded random + directed bench for dw02_mac at A_width=B_width=10; works with or without the output register.
module tb_dw02_mac;
  localparam int AW = 10;
  localparam int BW = 10;
  localparam int P  = AW + BW;
`ifdef DW02_MAC_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] a     = '0;
  logic [BW-1:0] b     = '0;
  logic [P-1:0]  c     = '0;
  logic          tc    = 1'b0;
  logic [P-1:0]  mac;

  dw02_mac #(.A_width(AW), .B_width(BW)) dut (
    .MAC_ACC_CLK (clk),
    .acc_ff_rstn (rst_n),
    .A           (a),
    .B           (b),
    .C           (c),
    .TC          (tc),
    .MAC         (mac)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [P-1:0] exp_q[$];
  logic         issue   = 1'b0;
  logic         issue_q = 1'b0;

  always @(posedge clk) issue_q <= issue;

  task automatic check(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (A=%h B=%h C=%h TC=%0d)", name, act, exp, a, b, c, tc);
    end
  endtask

  // Monitor: one result per issued vector, zero or one cycle after issue.
  always @(negedge clk) begin
    if (REG ? issue_q : issue) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got %h want <none>", mac);
      end else begin
        check("sb", mac, exp_q.pop_front());
      end
    end
  end

  // Reference: plain integer arithmetic on the interpreted operand values.
  function automatic logic [P-1:0] model(input logic [AW-1:0] ra, input logic [BW-1:0] rb,
                                         input logic [P-1:0] rc, input logic rtc);
    longint sa, sb, r;
    sa = longint'(ra);
    sb = longint'(rb);
    if (rtc && ra[AW-1]) sa -= longint'(1) << AW;
    if (rtc && rb[BW-1]) sb -= longint'(1) << BW;
    r = sa * sb + longint'(rc);
    return r[P-1:0];
  endfunction

  function automatic longint pick(input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return m;
      2:       return longint'(1) << (w - 1);
      3:       return (longint'(1) << (w - 1)) - 1;
      default: return longint'($urandom) & m;
    endcase
  endfunction

  task automatic apply(input logic [AW-1:0] ra, input logic [BW-1:0] rb, input logic [P-1:0] rc,
                       input logic rtc, input logic [P-1:0] exp);
    @(posedge clk);
    #1;
    a = ra; b = rb; c = rc; tc = rtc;
    issue = 1'b1;
    exp_q.push_back(exp);
  endtask

  initial begin
    #2;
    check("reset_state", mac, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    apply(10'd3,   10'd5,   20'h00000, 1'b0, 20'h0000F);
    apply(10'h3FF, 10'h3FF, 20'h00000, 1'b0, 20'hFF801);
    apply(10'h3FF, 10'h002, 20'h00000, 1'b1, 20'hFFFFE);
    apply(10'h3FF, 10'h3FF, 20'h00000, 1'b1, 20'h00001);
    apply(10'h200, 10'h200, 20'h00000, 1'b1, 20'h40000);
    apply(10'h3FF, 10'h3FF, 20'hFFFFF, 1'b0, 20'hFF800);
    apply(10'h001, 10'h001, 20'hFFFFF, 1'b1, 20'h00000);
    apply(10'h3FF, 10'h002, 20'h00000, 1'b0, 20'h007FE);
    apply(10'h3FF, 10'h002, 20'h00000, 1'b1, 20'hFFFFE);
    apply(10'h3FF, 10'h002, 20'h00000, 1'b0, 20'h007FE);

    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 10000; i++) begin
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        logic [P-1:0]  rc;
        ra = AW'(pick(AW));
        rb = BW'(pick(BW));
        rc = P'(pick(P));
        apply(ra, rb, rc, t[0], model(ra, rb, rc, t[0]));
      end
    end

    @(posedge clk);
    #1 issue = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end

`ifdef DW02_MAC_OUT_REG_EN
    @(posedge clk);
    #1 a = 10'd3; b = 10'd5; c = 20'd1; tc = 1'b0;
    @(posedge clk);
    #1 check("reg_load", mac, 20'h00010);
    #2 rst_n = 1'b0;
    #1 check("rst_async", mac, '0);
    @(posedge clk);
    #1 check("rst_hold", mac, '0);
    a = 10'd7; b = 10'd2; c = '0;
    rst_n = 1'b1;
    #1 check("rst_release", mac, '0);
    @(posedge clk);
    #1 check("rst_first_edge", mac, 20'd14);
`else
    @(posedge clk);
    #1 a = 10'd3; b = 10'd5; c = 20'd1; tc = 1'b0;
    #1 check("comb_load", mac, 20'h00010);
    rst_n = 1'b0;
    #1 check("rst_no_effect", mac, 20'h00010);
    a = 10'd7; b = 10'd2; c = '0;
    #1 check("rst_comb_live", mac, 20'd14);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dw02_mac.md
DW02_MAC -- requirements
Module: dw02_mac

Interface
REQ-001 A_width, default 8, bit width of multiplier operand A; minimum 2.
REQ-002 B_width, default 8, bit width of multiplier operand B; minimum 2.
REQ-003 MAC_ACC_CLK  input  1  single clock, rising edge, used only by the optional output register.
REQ-004 acc_ff_rstn  input  1  reset, asynchronous, active-low.
REQ-005 A  input  A_width  multiplier operand.
REQ-006 B  input  B_width  multiplicand operand.
REQ-007 C  input  A_width+B_width  addend.
REQ-008 TC  input  1  0 = operands unsigned, 1 = operands two's complement.
REQ-009 MAC  output  A_width+B_width  result A*B+C.

Function
REQ-010 With TC=0, MAC SHALL equal (unsigned(A)*unsigned(B) + unsigned(C)) mod 2^(A_width+B_width).
REQ-011 With TC=1, MAC SHALL equal (signed(A)*signed(B) + signed(C)) mod 2^(A_width+B_width), as a two's-complement bit pattern.
REQ-012 Overflow SHALL wrap silently; there is no saturation, no carry-out and no overflow flag.
REQ-013 The product SHALL be formed at full A_width+B_width precision before the add; there is no intermediate truncation.
REQ-014 TC SHALL act combinationally and may change on any cycle; the result reflects the current TC only.
REQ-015 The multiplier SHALL be implemented as a partial-product array with sign handling: Baugh-Wooley or sign-extended partial products selected by TC.
REQ-016 The adder tree SHALL be carry-save reduction followed by one final carry-propagate add that includes C.
REQ-017 Without the output register, MAC SHALL be purely combinational from A, B, C and TC, with zero latency and no state.
REQ-018 Inputs containing X/Z SHALL drive MAC to all-X in simulation.

Reset
REQ-019 acc_ff_rstn SHALL have no effect on the combinational datapath.
REQ-020 With the output register compiled in, asserting acc_ff_rstn low SHALL clear MAC to 0 immediately, independent of the clock.
REQ-021 MAC SHALL stay 0 while acc_ff_rstn is low.
REQ-022 After acc_ff_rstn is released, the first MAC_ACC_CLK rising edge SHALL load a valid result.
REQ-023 An assertion of acc_ff_rstn mid-stream SHALL discard the pending result.

Configuration
REQ-024 Macro DW02_MAC_OUT_REG_EN SHALL control the output register.
REQ-025 With DW02_MAC_OUT_REG_EN defined, MAC SHALL be registered on the rising edge of MAC_ACC_CLK, giving a latency of exactly one cycle from A/B/C/TC, with async reset to 0 per REQ-020.
REQ-026 With DW02_MAC_OUT_REG_EN undefined, MAC SHALL be combinational (REQ-017); MAC_ACC_CLK and acc_ff_rstn SHALL still exist as ports but are unused.

Verification (A_width=B_width=10, output 20 bits)
REQ-027 TC=0, A=3, B=5, C=0 -> MAC=20'h0000F; TC=0, A=10'h3FF, B=10'h3FF, C=0 -> MAC=20'hFF801.
REQ-028 TC=1, A=10'h3FF (-1), B=2, C=0 -> MAC=20'hFFFFE; TC=1, A=B=10'h3FF -> MAC=20'h00001; TC=1, A=B=10'h200 (-512) -> MAC=20'h40000.
REQ-029 Wrap: TC=0, A=B=10'h3FF, C=20'hFFFFF -> MAC=20'hFF800; TC=1, A=1, B=1, C=20'hFFFFF -> MAC=20'h00000.
REQ-030 TC toggle with fixed A=10'h3FF, B=10'h002, C=0: TC=0 -> 20'h007FE, TC=1 -> 20'hFFFFE, combinational or next edge per configuration.
REQ-031 With DW02_MAC_OUT_REG_EN defined:
- Apply A=3, B=5, C=1 -> MAC=20'h00010 one edge later.
- Then drive acc_ff_rstn low between edges -> MAC=0 at once.
- Release reset -> valid result on the next edge.
REQ-032 Random regression, 10k vectors per TC value, compared against the REQ-010/REQ-011 equations, covering all-ones, all-zeros, most-negative and most-positive operands.
